marker_frame_sync: RTL and testbench

//  Receive-side counterpart to the marker inserter. Takes the serial bit stream (data bit + valid strobe),

---
 rtl/marker_frame_sync.sv | 186 ++++++++++++++++++
 tb/tb_marker_frame_sync.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/marker_frame_sync.sv
// Receive-side frame synchroniser: detects the 44-bit frame markers, locks with a
// search/verify/locked flywheel and forwards only payload bits tagged with frame start and marker index.
module marker_frame_sync #(
  parameter int unsigned DATA_BITS  = 2816,
  parameter int unsigned ERR_TOL    = 0,
  parameter int unsigned CONFIRM    = 2,
  parameter int unsigned MISS_LIMIT = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       idat,
  input  logic       ival,
  output logic       odat,
  output logic       oval,
  output logic       ofirst,
  output logic [1:0] oidx,
  output logic       olock,
  output logic       omiss
);

  localparam int unsigned CFW = (CONFIRM > 1) ? $clog2(CONFIRM + 1) : 1;
  localparam int unsigned MSW = (MISS_LIMIT > 1) ? $clog2(MISS_LIMIT + 1) : 1;

  localparam logic [11:0]    DATA_END     = 12'(DATA_BITS);
  localparam logic [11:0]    CHECK_AT     = 12'(DATA_BITS + 43);
  localparam logic [CFW-1:0] CONFIRM_LAST = CFW'(CONFIRM - 1);
  localparam logic [MSW-1:0] MISS_LAST    = MSW'(MISS_LIMIT - 1);

  localparam logic [30:0] MK_M = 31'b1111100110100100001010111011000;
  localparam logic [12:0] MK_B = 13'b1111100110101;

  typedef enum logic [1:0] {
    SEARCH,
    VERIFY,
    LOCKED
  } state_t;

  // Index bit 0 inverts the long field, index bit 1 inverts the short field.
  function automatic logic [43:0] marker(input logic [1:0] k);
    logic [30:0] m;
    logic [12:0] b;
    m = k[0] ? ~MK_M : MK_M;
    b = k[1] ? ~MK_B : MK_B;
    return {m, b};
  endfunction

  state_t         state, state_n;
  // Only 43 history bits are kept; the oldest bit of the window is never needed again.
  logic [42:0]    sr, sr_n;
  logic [11:0]    cnt, cnt_n;
  logic [1:0]     exp_idx, exp_n;
  logic [CFW-1:0] confirm, confirm_n;
  logic [MSW-1:0] miss, miss_n;
  logic           odat_n, oval_n, ofirst_n, olock_n, omiss_n;
  logic [1:0]     oidx_n;

  logic [43:0]    w;
  logic [3:0]     hit;
  logic           any_hit;
  logic [1:0]     first_k;
  logic           exp_hit;
  logic           at_check;

  assign w        = {sr, idat};
  assign any_hit  = |hit;
  assign exp_hit  = hit[exp_idx];
  assign at_check = (cnt == CHECK_AT);

  always_comb begin
    hit     = '0;
    first_k = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      hit[k] = ($countones(w ^ marker(2'(k))) <= ERR_TOL);
    end
    for (int unsigned k = 4; k > 0; k--) begin
      if (hit[k-1]) first_k = 2'(k - 1);
    end
  end

  always_comb begin
    state_n   = state;
    sr_n      = sr;
    cnt_n     = cnt;
    exp_n     = exp_idx;
    confirm_n = confirm;
    miss_n    = miss;
    odat_n    = odat;
    oval_n    = 1'b0;
    ofirst_n  = 1'b0;
    oidx_n    = oidx;
    olock_n   = olock;
    omiss_n   = 1'b0;

    if (ival) begin
      sr_n = w[42:0];
      unique case (state)
        SEARCH: begin
          if (any_hit) begin
            exp_n     = first_k + 2'd1;
            cnt_n     = '0;
            confirm_n = '0;
            state_n   = VERIFY;
          end
        end

        VERIFY: begin
          if (at_check) begin
            cnt_n = '0;
            if (exp_hit) begin
              exp_n     = exp_idx + 2'd1;
              confirm_n = confirm + CFW'(1);
              if (confirm == CONFIRM_LAST) begin
                state_n = LOCKED;
                oidx_n  = exp_idx;
                miss_n  = '0;
                olock_n = 1'b1;
              end
            end else begin
              state_n = SEARCH;
            end
          end else begin
            cnt_n = cnt + 12'd1;
          end
        end

        LOCKED: begin
          if (at_check) begin
            cnt_n  = '0;
            oidx_n = exp_idx;
            exp_n  = exp_idx + 2'd1;
            if (exp_hit) begin
              miss_n = '0;
            end else begin
              omiss_n = 1'b1;
              miss_n  = miss + MSW'(1);
              if (miss == MISS_LAST) begin
                state_n = SEARCH;
                olock_n = 1'b0;
              end
            end
          end else begin
            cnt_n = cnt + 12'd1;
            if (cnt < DATA_END) begin
              odat_n   = idat;
              oval_n   = 1'b1;
              ofirst_n = (cnt == '0);
            end
          end
        end

        default: state_n = SEARCH;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= SEARCH;
      sr      <= '0;
      cnt     <= '0;
      exp_idx <= '0;
      confirm <= '0;
      miss    <= '0;
      odat    <= 1'b0;
      oval    <= 1'b0;
      ofirst  <= 1'b0;
      oidx    <= '0;
      olock   <= 1'b0;
      omiss   <= 1'b0;
    end else begin
      state   <= state_n;
      sr      <= sr_n;
      cnt     <= cnt_n;
      exp_idx <= exp_n;
      confirm <= confirm_n;
      miss    <= miss_n;
      odat    <= odat_n;
      oval    <= oval_n;
      ofirst  <= ofirst_n;
      oidx    <= oidx_n;
      olock   <= olock_n;
      omiss   <= omiss_n;
    end
  end

endmodule

// File: tb/tb_marker_frame_sync.sv
// Directed bench for marker_frame_sync: a short-frame instance with ERR_TOL=0 and a twin with
// ERR_TOL=1 share one serial stream; each task builds a marker/payload scenario and checks inline.
module tb_marker_frame_sync;

  localparam int unsigned DB = 64;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       idat = 1'b0;
  logic       ival = 1'b0;
  logic       odat0, oval0, ofirst0, olock0, omiss0;
  logic [1:0] oidx0;
  logic       odat1, oval1, ofirst1, olock1, omiss1;
  logic [1:0] oidx1;

  int tests_run = 0;
  int n_fail    = 0;
  int gap       = 0;

  logic exp_q[$];
  logic rx_q[$];
  int   first_cnt, first_pos, miss0, miss1, lock_rise;
  logic lock_prev = 1'b0;

  marker_frame_sync #(.DATA_BITS(DB), .ERR_TOL(0), .CONFIRM(2), .MISS_LIMIT(3)) u_dut0 (
    .clk(clk), .reset(reset), .idat(idat), .ival(ival),
    .odat(odat0), .oval(oval0), .ofirst(ofirst0), .oidx(oidx0), .olock(olock0), .omiss(omiss0)
  );

  marker_frame_sync #(.DATA_BITS(DB), .ERR_TOL(1), .CONFIRM(2), .MISS_LIMIT(3)) u_dut1 (
    .clk(clk), .reset(reset), .idat(idat), .ival(ival),
    .odat(odat1), .oval(oval1), .ofirst(ofirst1), .oidx(oidx1), .olock(olock1), .omiss(omiss1)
  );

  always #5 clk = ~clk;

  // Output recorder, sampled on the falling edge away from the active edge.
  always @(negedge clk) begin
    if (oval0) begin
      if (ofirst0) begin
        first_cnt++;
        first_pos = rx_q.size();
      end
      rx_q.push_back(odat0);
    end
    if (omiss0) miss0++;
    if (omiss1) miss1++;
    if (olock0 && !lock_prev) lock_rise++;
    lock_prev = olock0;
  end

  function automatic logic [43:0] mk(input int k);
    logic [30:0] m;
    logic [12:0] b;
    m = 31'b1111100110100100001010111011000;
    b = 13'b1111100110101;
    case (k)
      0:       return {m, b};
      1:       return {~m, b};
      2:       return {m, ~b};
      default: return {~m, ~b};
    endcase
  endfunction

  function automatic int payload_errs();
    int e;
    e = 0;
    if (exp_q.size() == 0 || rx_q.size() != exp_q.size()) return 9999;
    foreach (rx_q[i]) if (rx_q[i] !== exp_q[i]) e++;
    return e;
  endfunction

  task automatic clear_mon();
    rx_q.delete();
    exp_q.delete();
    first_cnt = 0;
    first_pos = -1;
    miss0     = 0;
    miss1     = 0;
    lock_rise = 0;
  endtask

  task automatic send_bit(input logic b);
    idat = b;
    ival = 1'b1;
    @(negedge clk);
    if (gap != 0) begin
      ival = 1'b0;
      repeat (gap) @(negedge clk);
    end
  endtask

  task automatic send_marker(input int k, input logic [43:0] mask = '0);
    logic [43:0] v;
    v = mk(k) ^ mask;
    for (int i = 43; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic send_payload(input bit rec);
    for (int i = 0; i < int'(DB); i++) begin
      logic b;
      b = 1'($urandom_range(0, 1));
      if (rec) exp_q.push_back(b);
      send_bit(b);
    end
  endtask

  task automatic send_random(input int n);
    for (int i = 0; i < n; i++) send_bit(1'($urandom_range(0, 1)));
  endtask

  task automatic idle(input int n);
    ival = 1'b0;
    idat = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    ival  = 1'b0;
    idat  = 1'b0;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    clear_mon();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    @(negedge clk);
    tests_run++;
    if ({odat0, oval0, ofirst0, oidx0, olock0, omiss0} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b want 0000000", {odat0, oval0, ofirst0, oidx0, olock0, omiss0});
    end
    do_reset();
  endtask

  task automatic test_clean_stream();
    do_reset();
    gap = 3;
    send_marker(0); send_payload(0); send_marker(1); send_payload(0);
    idle(2);
    tests_run++;
    if (olock0 !== 1'b0) begin n_fail++; $display("FAIL t1_prelock: olock=%b want 0", olock0); end
    send_marker(2);
    idle(2);
    tests_run++;
    if (olock0 !== 1'b1) begin n_fail++; $display("FAIL t1_lock: olock=%b want 1", olock0); end
    tests_run++;
    if (rx_q.size() != 0) begin n_fail++; $display("FAIL t1_no_early_oval: %0d bits want 0", rx_q.size()); end
    send_payload(1);
    idle(2);
    tests_run++;
    if (payload_errs() != 0) begin n_fail++; $display("FAIL t1_payload: errs=%0d want 0", payload_errs()); end
    tests_run++;
    if (first_cnt != 1 || first_pos != 0) begin
      n_fail++; $display("FAIL t1_ofirst: count=%0d pos=%0d want 1/0", first_cnt, first_pos);
    end
    tests_run++;
    if (oidx0 !== 2'd2) begin n_fail++; $display("FAIL t1_oidx: got %0d want 2", oidx0); end
    gap = 0;
  endtask

  task automatic test_midframe_acquire();
    do_reset();
    gap = 0;
    send_random(1000);
    idle(2);
    tests_run++;
    if (rx_q.size() != 0 || olock0 !== 1'b0) begin
      n_fail++; $display("FAIL t2_search_quiet: oval bits=%0d olock=%b want 0/0", rx_q.size(), olock0);
    end
    send_marker(1); send_payload(0); send_marker(2); send_payload(0);
    idle(2);
    tests_run++;
    if (rx_q.size() != 0 || olock0 !== 1'b0) begin
      n_fail++; $display("FAIL t2_verify_quiet: oval bits=%0d olock=%b want 0/0", rx_q.size(), olock0);
    end
    send_marker(3);
    idle(2);
    tests_run++;
    if (olock0 !== 1'b1 || oidx0 !== 2'd3) begin
      n_fail++; $display("FAIL t2_lock: olock=%b oidx=%0d want 1/3", olock0, oidx0);
    end
    send_payload(1);
    idle(2);
    tests_run++;
    if (payload_errs() != 0) begin n_fail++; $display("FAIL t2_payload: errs=%0d want 0", payload_errs()); end
  endtask

  task automatic test_corrupt_marker();
    clear_mon();
    send_marker(0, 44'h000_0010_0000);
    idle(2);
    tests_run++;
    if (miss0 != 1) begin n_fail++; $display("FAIL t3_omiss_once: pulses=%0d want 1", miss0); end
    tests_run++;
    if (olock0 !== 1'b1) begin n_fail++; $display("FAIL t3_lock_held: olock=%b want 1", olock0); end
    tests_run++;
    if (miss1 != 0 || olock1 !== 1'b1) begin
      n_fail++; $display("FAIL t3_tol1_no_miss: pulses=%0d olock=%b want 0/1", miss1, olock1);
    end
    clear_mon();
    send_payload(1);
    send_marker(1);
    idle(2);
    tests_run++;
    if (payload_errs() != 0 || first_pos != 0) begin
      n_fail++; $display("FAIL t3_aligned: errs=%0d first_pos=%0d want 0/0", payload_errs(), first_pos);
    end
    tests_run++;
    if (miss0 != 0 || oidx0 !== 2'd1) begin
      n_fail++; $display("FAIL t3_next_marker: misses=%0d oidx=%0d want 0/1", miss0, oidx0);
    end
  endtask

  task automatic test_lose_lock();
    clear_mon();
    for (int r = 0; r < 2; r++) begin
      send_payload(0);
      send_random(44);
    end
    idle(2);
    tests_run++;
    if (olock0 !== 1'b1 || miss0 != 2) begin
      n_fail++; $display("FAIL t4_flywheel: olock=%b misses=%0d want 1/2", olock0, miss0);
    end
    send_payload(0);
    send_random(44);
    idle(2);
    tests_run++;
    if (olock0 !== 1'b0 || miss0 != 3) begin
      n_fail++; $display("FAIL t4_drop: olock=%b misses=%0d want 0/3", olock0, miss0);
    end
    clear_mon();
    send_payload(0); send_marker(1); send_payload(0); send_marker(2);
    idle(2);
    tests_run++;
    if (olock0 !== 1'b0) begin n_fail++; $display("FAIL t4_verify: olock=%b want 0", olock0); end
    send_payload(0); send_marker(3);
    idle(2);
    tests_run++;
    if (olock0 !== 1'b1 || oidx0 !== 2'd3) begin
      n_fail++; $display("FAIL t4_relock: olock=%b oidx=%0d want 1/3", olock0, oidx0);
    end
  endtask

  task automatic test_out_of_order();
    do_reset();
    send_marker(0); send_payload(0); send_marker(2); send_payload(0);
    send_marker(3); send_payload(0); send_marker(1); send_payload(0);
    send_marker(2);
    idle(2);
    tests_run++;
    if (lock_rise != 0 || olock0 !== 1'b0) begin
      n_fail++; $display("FAIL t5_no_lock: rises=%0d olock=%b want 0/0", lock_rise, olock0);
    end
    tests_run++;
    if (rx_q.size() != 0) begin n_fail++; $display("FAIL t5_no_output: %0d bits want 0", rx_q.size()); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    gap = 0;
    send_marker(0); send_payload(0); send_marker(1); send_payload(0); send_marker(2);
    idle(2);
    tests_run++;
    if (olock0 !== 1'b1) begin n_fail++; $display("FAIL t6_lock: olock=%b want 1", olock0); end
    send_payload(1);
    idle(2);
    tests_run++;
    if (payload_errs() != 0 || first_cnt != 1 || first_pos != 0 || oidx0 !== 2'd2) begin
      n_fail++;
      $display("FAIL t6_payload: errs=%0d firsts=%0d pos=%0d oidx=%0d want 0/1/0/2",
               payload_errs(), first_cnt, first_pos, oidx0);
    end
    send_marker(3);
    send_random(20);
    reset = 1'b0;
    @(negedge clk);
    tests_run++;
    if ({odat0, oval0, ofirst0, oidx0, olock0, omiss0} !== 7'b0) begin
      n_fail++;
      $display("FAIL t6_reset_mid: got %b want 0000000", {odat0, oval0, ofirst0, oidx0, olock0, omiss0});
    end
    ival = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    clear_mon();
    send_marker(0); send_payload(0); send_marker(1); send_payload(0);
    idle(2);
    tests_run++;
    if (olock0 !== 1'b0) begin n_fail++; $display("FAIL t6_search_after_reset: olock=%b want 0", olock0); end
    send_marker(2);
    idle(2);
    tests_run++;
    if (olock0 !== 1'b1) begin n_fail++; $display("FAIL t6_relock: olock=%b want 1", olock0); end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    test_reset();
    test_clean_stream();
    test_midframe_acquire();
    test_corrupt_marker();
    test_lose_lock();
    test_out_of_order();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, n_fail);
    $finish;
  end

endmodule
